blink_monitor: RTL and testbench

Measures a free-running square-wave input, such as a blinker output or an off-board heartbeat, and reports the high time, low time and period in clock cycles. The block is the receive end of the blink interface: the blinker drives the pin, and blink_monitor checks it. It also flags a stuck input when no edge arrives within 2^WIDTH-1 cycles. Status logic and self-test loopbacks sit downstream and consume its outputs.

---
 rtl/blink_monitor_pkg.sv | 10 +
 rtl/blink_monitor_sync_edge.sv | 32 +++
 rtl/blink_monitor.sv | 136 +++++++++++++
 tb/tb_blink_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_monitor_pkg.sv
// Types shared by the blink monitor and its pin front end.
package blink_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } blinkState_t;

endpackage

// File: rtl/blink_monitor_sync_edge.sv
// Two-flop synchronizer plus history flop with rise/fall detection.
// Reusable front end for any single-pin monitor.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= din_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~s3_q;
   assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/blink_monitor.sv
// Measures high time, low time and period of a square-wave pin and flags
// a pin that has shown no edge for a full saturated counter span.
module blink_monitor
   import blink_monitor_pkg::*;
#(
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             blink_in,
   output logic [WIDTH-1:0] high_time,
   output logic [WIDTH-1:0] low_time,
   output logic [WIDTH:0]   period,
   output logic             meas_valid,
   output logic             stuck,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic syncLevel;
   logic syncRise;
   logic syncFall;
   logic edgeSeen;
   logic cntSat;

   blinkState_t      state_q,      state_d;
   logic [WIDTH-1:0] cnt_q,        cnt_d;
   logic [WIDTH-1:0] hiHold_q,     hiHold_d;
   logic [WIDTH-1:0] highTime_q,   highTime_d;
   logic [WIDTH-1:0] lowTime_q,    lowTime_d;
   logic [WIDTH:0]   period_q,     period_d;
   logic             measValid_q,  measValid_d;
   logic             stuck_q,      stuck_d;
   logic             stuckLevel_q, stuckLevel_d;

   sync_edge uSync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (blink_in),
      .level_o (syncLevel),
      .rise_o  (syncRise),
      .fall_o  (syncFall)
   );

   assign edgeSeen = syncRise | syncFall;
   assign cntSat   = (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hiHold_q     <= '0;
         highTime_q   <= '0;
         lowTime_q    <= '0;
         period_q     <= '0;
         measValid_q  <= 1'b0;
         stuck_q      <= 1'b0;
         stuckLevel_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hiHold_q     <= hiHold_d;
         highTime_q   <= highTime_d;
         lowTime_q    <= lowTime_d;
         period_q     <= period_d;
         measValid_q  <= measValid_d;
         stuck_q      <= stuck_d;
         stuckLevel_q <= stuckLevel_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hiHold_d     = hiHold_q;
      highTime_d   = highTime_q;
      lowTime_d    = lowTime_q;
      period_d     = period_q;
      measValid_d  = 1'b0;
      stuck_d      = stuck_q;
      stuckLevel_d = stuckLevel_q;

      // The counter runs in every state so a pin frozen since reset still saturates.
      if (edgeSeen) begin
         cnt_d = CNT_ONE;
      end else if (!cntSat) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (syncRise) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (syncFall) begin
               hiHold_d = cnt_q;
               state_d  = LOW;
            end
         end
         LOW: begin
            if (syncRise) begin
               highTime_d  = hiHold_q;
               lowTime_d   = cnt_q;
               period_d    = {1'b0, hiHold_q} + {1'b0, cnt_q};
               measValid_d = 1'b1;
               state_d     = HIGH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An edge on the saturation cycle wins; only a silent saturated cycle is stuck.
      if (edgeSeen) begin
         stuck_d = 1'b0;
      end else if (cntSat) begin
         stuck_d      = 1'b1;
         stuckLevel_d = syncLevel;
         hiHold_d     = '0;
         state_d      = IDLE;
      end
   end

   assign high_time   = highTime_q;
   assign low_time    = lowTime_q;
   assign period      = period_q;
   assign meas_valid  = measValid_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuckLevel_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Drives two blink_monitor instances (WIDTH 22 and 4) from one pin and
// compares them against a run-length reference model every cycle.
`timescale 1ns/1ps
module tb_blink_monitor;

   localparam int W22 = 22;
   localparam int W4  = 4;

   logic           clk;
   logic           rst;
   logic           blinkIn;
   logic [W22-1:0] highTime22;
   logic [W22-1:0] lowTime22;
   logic [W22:0]   period22;
   logic           measValid22;
   logic           stuck22;
   logic           stuckLevel22;
   logic [W4-1:0]  highTime4;
   logic [W4-1:0]  lowTime4;
   logic [W4:0]    period4;
   logic           measValid4;
   logic           stuck4;
   logic           stuckLevel4;

   blink_monitor #(.WIDTH(W22)) dut22 (
      .clk         (clk),
      .rst         (rst),
      .blink_in    (blinkIn),
      .high_time   (highTime22),
      .low_time    (lowTime22),
      .period      (period22),
      .meas_valid  (measValid22),
      .stuck       (stuck22),
      .stuck_level (stuckLevel22)
   );

   blink_monitor #(.WIDTH(W4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .blink_in    (blinkIn),
      .high_time   (highTime4),
      .low_time    (lowTime4),
      .period      (period4),
      .meas_valid  (measValid4),
      .stuck       (stuck4),
      .stuck_level (stuckLevel4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int hiCyc;
      int loCyc;
      int reps;
      int expHi;
      int expLo;
      int expPer;
      int expStrobes;
      int expFirst;
      int expStrobes4;
      int expStuck4;
   } vecT;

   vecT vecs [5];

   int checks  = 0;
   int passed  = 0;
   int cyc     = 0;
   int baseCyc = 0;

   int maxVal [2];
   bit m1, m2, m3;
   int runLen    [2];
   bit armHigh   [2];
   bit armLow    [2];
   int hiLen     [2];
   int expHigh   [2];
   int expLow    [2];
   int expPeriod [2];
   bit expMv     [2];
   bit expStuck  [2];
   bit expLvl    [2];

   int strobeCnt     [2];
   int firstStrobe   [2];
   int lastStrobeCyc [2];
   int stuckSetCyc   [2];
   int stuckClrCyc   [2];
   bit stuckSeen     [2];
   bit prevMv        [2];
   bit prevStuck     [2];

   bit tblActive = 1'b0;
   bit tblCheck4 = 1'b0;
   int tblHi, tblLo, tblPer;

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic clearStats();
      for (int i = 0; i < 2; i++) begin
         strobeCnt[i]     = 0;
         firstStrobe[i]   = -1;
         lastStrobeCyc[i] = -1;
         stuckSetCyc[i]   = -1;
         stuckClrCyc[i]   = -1;
         stuckSeen[i]     = 1'b0;
      end
      baseCyc = cyc + 1;
   endtask

   // Reference: the pin is a sequence of runs; a run's recorded length is its
   // cycle count capped at the counter maximum, and a run lasting past the
   // maximum marks the pin stuck and forgets any half-finished measurement.
   task automatic modelStep(input bit v, input bit r);
      bit y;
      bit prev;
      int ended;
      if (r) begin
         m1 = 0; m2 = 0; m3 = 0;
         for (int i = 0; i < 2; i++) begin
            runLen[i] = 0; armHigh[i] = 0; armLow[i] = 0; hiLen[i] = 0;
            expHigh[i] = 0; expLow[i] = 0; expPeriod[i] = 0;
            expMv[i] = 0; expStuck[i] = 0; expLvl[i] = 0;
         end
      end else begin
         y    = m2;
         prev = m3;
         for (int i = 0; i < 2; i++) begin
            expMv[i] = 0;
            if (y != prev) begin
               ended = (runLen[i] > maxVal[i]) ? maxVal[i] : runLen[i];
               expStuck[i] = 0;
               if (y) begin
                  if (armLow[i]) begin
                     expHigh[i]   = hiLen[i];
                     expLow[i]    = ended;
                     expPeriod[i] = hiLen[i] + ended;
                     expMv[i]     = 1;
                  end
                  armHigh[i] = 1;
                  armLow[i]  = 0;
               end else begin
                  if (armHigh[i]) begin
                     hiLen[i]  = ended;
                     armLow[i] = 1;
                  end
                  armHigh[i] = 0;
               end
               runLen[i] = 1;
            end else begin
               if (runLen[i] >= maxVal[i]) begin
                  expStuck[i] = 1;
                  expLvl[i]   = y;
                  armHigh[i]  = 0;
                  armLow[i]   = 0;
               end
               if (runLen[i] <= maxVal[i]) runLen[i]++;
            end
         end
         m3 = m2;
         m2 = m1;
         m1 = v;
      end
   endtask

   task automatic checkOutput();
      int actHigh [2];
      int actLow  [2];
      int actPer  [2];
      bit actMv   [2];
      bit actStk  [2];
      bit actLvl  [2];
      int w;
      actHigh[0] = int'(highTime22); actLow[0] = int'(lowTime22); actPer[0] = int'(period22);
      actMv[0] = measValid22; actStk[0] = stuck22; actLvl[0] = stuckLevel22;
      actHigh[1] = int'(highTime4);  actLow[1] = int'(lowTime4);  actPer[1] = int'(period4);
      actMv[1] = measValid4;  actStk[1] = stuck4;  actLvl[1] = stuckLevel4;
      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? W22 : W4;
         checks++;
         if (actHigh[i] == expHigh[i] && actLow[i] == expLow[i] && actPer[i] == expPeriod[i] &&
             actMv[i] == expMv[i] && actStk[i] == expStuck[i] && actLvl[i] == expLvl[i]) begin
            passed++;
         end else begin
            $display("[TB] FAIL model_w%0d cycle %0d: got hi=%0d lo=%0d per=%0d mv=%0b stuck=%0b lvl=%0b, expected hi=%0d lo=%0d per=%0d mv=%0b stuck=%0b lvl=%0b",
                     w, cyc, actHigh[i], actLow[i], actPer[i], actMv[i], actStk[i], actLvl[i],
                     expHigh[i], expLow[i], expPeriod[i], expMv[i], expStuck[i], expLvl[i]);
         end
         if (actMv[i]) begin
            checkVal($sformatf("strobe_gap_w%0d", w), int'(prevMv[i]), 0);
            strobeCnt[i]++;
            lastStrobeCyc[i] = cyc;
            if (firstStrobe[i] < 0) firstStrobe[i] = cyc - baseCyc;
            if (tblActive && (i == 0 || tblCheck4)) begin
               checkVal($sformatf("table_high_w%0d", w), actHigh[i], tblHi);
               checkVal($sformatf("table_low_w%0d", w), actLow[i], tblLo);
               checkVal($sformatf("table_period_w%0d", w), actPer[i], tblPer);
            end
         end
         if (actStk[i] && !prevStuck[i]) begin
            stuckSeen[i]   = 1'b1;
            stuckSetCyc[i] = cyc;
         end
         if (!actStk[i] && prevStuck[i]) stuckClrCyc[i] = cyc;
         prevMv[i]    = actMv[i];
         prevStuck[i] = actStk[i];
      end
   endtask

   task automatic applyStimulus(input bit v, input bit r);
      @(negedge clk);
      blinkIn = v;
      rst     = r;
      @(posedge clk);
      cyc++;
      modelStep(v, r);
      #1;
      checkOutput();
   endtask

   task automatic applyPattern(input int hi, input int lo, input int reps);
      for (int k = 0; k < reps; k++) begin
         repeat (hi) applyStimulus(1'b1, 1'b0);
         repeat (lo) applyStimulus(1'b0, 1'b0);
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected self-termination");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int holdStart;
      int fallStart;
      int cntBefore;
      int rstCyc;
      bit lvl;
      int len;

      maxVal[0] = (1 << W22) - 1;
      maxVal[1] = (1 << W4) - 1;
      for (int i = 0; i < 2; i++) begin
         prevMv[i] = 0;
         prevStuck[i] = 0;
      end
      rst     = 1'b1;
      blinkIn = 1'b0;

      vecs[0] = '{8,  8, 4,  8, 8, 16, 3, 18, 3, 0};
      vecs[1] = '{3,  5, 4,  3, 5,  8, 3, 10, 3, 0};
      vecs[2] = '{1,  1, 6,  1, 1,  2, 5,  4, 5, 0};
      vecs[3] = '{15, 3, 3, 15, 3, 18, 2, 20, 2, 0};
      vecs[4] = '{16, 3, 3, 16, 3, 19, 2, 21, 0, 1};

      applyStimulus(1'b0, 1'b1);
      checkVal("reset_high_time", int'(highTime22), 0);
      checkVal("reset_period", int'(period22), 0);
      checkVal("reset_meas_valid", int'(measValid22), 0);
      checkVal("reset_stuck", int'(stuck4), 0);

      for (int t = 0; t < 5; t++) begin
         applyStimulus(1'b0, 1'b1);
         clearStats();
         tblHi     = vecs[t].expHi;
         tblLo     = vecs[t].expLo;
         tblPer    = vecs[t].expPer;
         tblCheck4 = (vecs[t].expStrobes4 > 0);
         tblActive = 1'b1;
         applyPattern(vecs[t].hiCyc, vecs[t].loCyc, vecs[t].reps);
         repeat (6) applyStimulus(1'b0, 1'b0);
         tblActive = 1'b0;
         checkVal($sformatf("vec%0d_strobes_w22", t), strobeCnt[0], vecs[t].expStrobes);
         checkVal($sformatf("vec%0d_first_strobe", t), firstStrobe[0], vecs[t].expFirst);
         checkVal($sformatf("vec%0d_strobes_w4", t), strobeCnt[1], vecs[t].expStrobes4);
         checkVal($sformatf("vec%0d_stuck_w4", t), int'(stuckSeen[1]), vecs[t].expStuck4);
      end

      // Stuck high on the narrow instance, then recovery with a 4/4 toggle.
      applyStimulus(1'b0, 1'b1);
      clearStats();
      applyPattern(8, 8, 3);
      holdStart = cyc + 1;
      repeat (30) applyStimulus(1'b1, 1'b0);
      checkVal("stuck_high_set_cycle", stuckSetCyc[1], holdStart + 17);
      checkVal("stuck_high_flag", int'(stuck4), 1);
      checkVal("stuck_high_level", int'(stuckLevel4), 1);
      checkVal("stuck_hold_high", int'(highTime4), 8);
      checkVal("stuck_hold_low", int'(lowTime4), 8);
      checkVal("stuck_hold_period", int'(period4), 16);
      checkVal("stuck_last_strobe", lastStrobeCyc[1], holdStart + 2);
      checkVal("stuck_w22_clear", int'(stuck22), 0);
      fallStart = cyc + 1;
      cntBefore = strobeCnt[1];
      applyPattern(0, 4, 1);
      applyPattern(4, 4, 1);
      applyPattern(4, 4, 1);
      checkVal("stuck_clear_cycle", stuckClrCyc[1], fallStart + 2);
      checkVal("resume_strobe_cycle", lastStrobeCyc[1], fallStart + 14);
      checkVal("resume_strobe_count", strobeCnt[1] - cntBefore, 1);
      checkVal("resume_high", int'(highTime4), 4);
      checkVal("resume_low", int'(lowTime4), 4);
      checkVal("resume_period", int'(period4), 8);

      // Reset in the middle of a low phase.
      applyStimulus(1'b0, 1'b1);
      applyPattern(8, 8, 2);
      applyPattern(8, 5, 1);
      applyStimulus(1'b0, 1'b1);
      checkVal("midrst_high", int'(highTime22), 0);
      checkVal("midrst_low", int'(lowTime22), 0);
      checkVal("midrst_period", int'(period22), 0);
      checkVal("midrst_valid", int'(measValid22), 0);
      checkVal("midrst_period_w4", int'(period4), 0);
      clearStats();
      repeat (4) applyStimulus(1'b0, 1'b0);
      applyPattern(8, 8, 3);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkVal("midrst_first_strobe", firstStrobe[0], 4 + 16 + 2);
      checkVal("midrst_strobe_count", strobeCnt[0], 2);

      // Pin held low from reset.
      applyStimulus(1'b0, 1'b1);
      rstCyc = cyc;
      clearStats();
      repeat (20) applyStimulus(1'b0, 1'b0);
      checkVal("lowstuck_set_cycle", stuckSetCyc[1], rstCyc + 16);
      checkVal("lowstuck_flag", int'(stuck4), 1);
      checkVal("lowstuck_level", int'(stuckLevel4), 0);
      checkVal("lowstuck_w22", int'(stuck22), 0);

      // Random run lengths with occasional resets and long runs.
      lvl = 1'b1;
      for (int seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 9) == 0) applyStimulus(lvl, 1'b1);
         if ($urandom_range(0, 6) == 0) len = $urandom_range(14, 24);
         else len = $urandom_range(1, 12);
         repeat (len) applyStimulus(lvl, 1'b0);
         lvl = ~lvl;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
